soc_event_queue: RTL



---
 rtl/soc_event_pkg.sv | 9 +
 rtl/soc_event_rr_arbiter.sv | 34 +++
 rtl/soc_event_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/soc_event_pkg.sv
// Shared event-queue types and defaults, also used by the fabric-controller subsystem top.
package soc_event_pkg;

    localparam int unsigned NB_SOURCES_DEF     = 32;
    localparam int unsigned EVENT_ID_WIDTH_DEF = 8;

    typedef logic [EVENT_ID_WIDTH_DEF-1:0] event_id_t;

endpackage

// File: rtl/soc_event_rr_arbiter.sv
// Combinational round-robin arbiter: first requester found at or after ptr, wrapping at NB_SOURCES.
module soc_event_rr_arbiter
    import soc_event_pkg::*;
#(
    parameter  int unsigned NB_SOURCES = NB_SOURCES_DEF,
    localparam int unsigned PTR_W      = $clog2(NB_SOURCES)
) (
    input  logic [NB_SOURCES-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    input  logic                  en,
    output logic                  gnt_valid,
    output logic [PTR_W-1:0]      gnt_idx
);

    int unsigned w_cand;

    // Explicit modulo wrap keeps non-power-of-two source counts correct.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_cand    = 0;
        for (int unsigned i = 0; i < NB_SOURCES; i++) begin
            w_cand = 32'(ptr) + i;
            if (w_cand >= NB_SOURCES) begin
                w_cand = w_cand - NB_SOURCES;
            end
            if (en && !gnt_valid && req[w_cand[PTR_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/soc_event_queue.sv
// Per-source pending flags, round-robin serialisation into a small FIFO, and lost-event reporting.
module soc_event_queue
    import soc_event_pkg::*;
#(
    parameter int unsigned NB_SOURCES     = NB_SOURCES_DEF,
    parameter int unsigned EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_SOURCES-1:0]     evt_i,
    output logic                      evt_valid_o,
    input  logic                      evt_fulln_i,
    output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
    output logic                      err_o,
    output logic [EVENT_ID_WIDTH-1:0] err_id_o
);

    localparam int unsigned PTR_W = $clog2(NB_SOURCES);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [NB_SOURCES-1:0]     r_pending;
    logic [PTR_W-1:0]          r_rr_ptr;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic [EVENT_ID_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                      r_err;
    logic [EVENT_ID_WIDTH-1:0] r_err_id;

    logic                      w_not_full;
    logic                      w_gnt_valid;
    logic [PTR_W-1:0]          w_gnt_idx;
    logic [NB_SOURCES-1:0]     w_gnt_onehot;
    logic [NB_SOURCES-1:0]     w_lost;
    logic [EVENT_ID_WIDTH-1:0] w_lost_id;
    logic                      w_pop;

    // A full FIFO blocks the push even when the head is popped in the same cycle.
    assign w_not_full = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_pop      = evt_valid_o && evt_fulln_i;

    soc_event_rr_arbiter #(
        .NB_SOURCES (NB_SOURCES)
    ) u_arb (
        .req       (r_pending),
        .ptr       (r_rr_ptr),
        .en        (w_not_full),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // A re-fire on the granted source is not a loss: set wins over clear.
    always_comb begin
        w_gnt_onehot = '0;
        if (w_gnt_valid) begin
            w_gnt_onehot[w_gnt_idx] = 1'b1;
        end
        w_lost    = evt_i & r_pending & ~w_gnt_onehot;
        w_lost_id = '0;
        for (int k = NB_SOURCES - 1; k >= 0; k--) begin
            if (w_lost[k]) begin
                w_lost_id = EVENT_ID_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_err_id  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_gnt_onehot) | evt_i;
            r_err     <= |w_lost;
            r_err_id  <= w_lost_id;
            if (w_gnt_valid) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rr_ptr <= (w_gnt_idx == PTR_W'(NB_SOURCES - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_gnt_valid, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the output mux masks it while empty.
    always_ff @(posedge clk_i) begin
        if (w_gnt_valid) begin
            r_mem[r_wr_ptr] <= EVENT_ID_WIDTH'(w_gnt_idx);
        end
    end

    assign evt_valid_o = (r_count != '0);
    assign evt_data_o  = evt_valid_o ? r_mem[r_rd_ptr] : '0;
    assign err_o       = r_err;
    assign err_id_o    = r_err_id;

endmodule
